// File: rtl/sram_controller.sv
// sram_controller: memory-request responder driving a 16-bit off-chip SRAM.
//   clk, rst              clock, asynchronous active-high reset
//   wr_en, rd_en          level requests (32-bit word write / 64-bit line read), held until ready
//   address, writeData    byte address and write word, latched when a request is accepted
//   readData              64-bit read line, halfword k at [16k+15:16k], held between reads
//   ready                 0 while an access is in flight (pipeline freeze)
//   SRAM_DQ, SRAM_ADDR    SRAM data bus (driven only on write beats) and halfword address
//   SRAM_WE_N             active-low SRAM write strobe
module sram_controller #(
    parameter int LATENCY   = 6,
    parameter int DATA_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [63:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_k;
    logic          r_wr;
    logic [31:0]   r_wdata, w_off;
    logic [17:0]   w_wb, w_rb;
    logic          w_req, w_drive, w_step, w_unused_off;

    assign w_req        = wr_en | rd_en;
    assign w_off        = address - 32'(DATA_BASE);
    assign w_wb         = {w_off[18:2], 1'b0};
    assign w_rb         = {w_off[18:3], 2'b00};
    assign w_unused_off = ^{w_off[31:19], w_off[1:0]};
    assign w_k          = r_cnt - CW'(1);
    // Write beats are k=0,1; the bus is released in every other cycle.
    assign w_drive      = (r_state == ACCESS) && r_wr && (w_k < CW'(2));
    // Advance the SRAM address only between beats so it holds the last beat's address in padding.
    assign w_step       = w_k < (r_wr ? CW'(1) : CW'(3));
    assign SRAM_WE_N    = ~w_drive;
    assign SRAM_DQ      = w_drive ? (w_k[0] ? r_wdata[31:16] : r_wdata[15:0]) : 16'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)   ? (w_req ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? ((r_cnt == CW'(LATENCY - 1)) ? DONE : ACCESS) :
                                       IDLE;
        ready  = (r_state == IDLE) ? ~w_req : (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            SRAM_ADDR <= '0;
            readData  <= '0;
        end else if (r_state == IDLE) begin
            if (w_req) begin
                r_cnt     <= CW'(1);
                r_wr      <= wr_en;
                r_wdata   <= writeData;
                SRAM_ADDR <= wr_en ? w_wb : w_rb;
            end
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_step)
                SRAM_ADDR <= SRAM_ADDR + 18'd1;
            if (!r_wr && (w_k < CW'(4)))
                readData[{w_k[1:0], 4'b0000} +: 16] <= SRAM_DQ;
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table vectors, hand sequences and random ops against a line/halfword memory model.
module tb_sram_controller;
    localparam int LATENCY = 6;
    localparam int BASE    = 1024;
    localparam int NHW     = 1 << 18;
    localparam logic [15:0] PRE [8] = '{16'h0a0a, 16'h0b0b, 16'h0102, 16'h0304,
                                        16'h1111, 16'h2222, 16'h3333, 16'h4444};

    logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, sram_oe = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic [63:0] readData;
    logic        ready, SRAM_WE_N;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;

    bit   [15:0] mem [NHW];
    bit          wrt [NHW];
    logic [15:0] ref_mem [int];
    logic [63:0] ref_rd = '0;
    int          checks = 0, errors = 0;

    sram_controller #(.LATENCY(LATENCY), .DATA_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i < 8) return PRE[i];
        if (i >= NHW - 4) return 16'h00A0 + 16'(i - (NHW - 4));
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] sram_at(input int i);
        return wrt[i] ? mem[i] : init_val(i);
    endfunction

    // SRAM device: drives the bus only when enabled and not being written.
    assign SRAM_DQ = (sram_oe && SRAM_WE_N) ? sram_at(int'(SRAM_ADDR)) : 16'bz;
    always @(posedge clk)
        if (!SRAM_WE_N) begin
            mem[SRAM_ADDR] <= SRAM_DQ;
            wrt[SRAM_ADDR] <= 1'b1;
        end

    function automatic int hw_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return int'(off >> 1) % NHW;
    endfunction

    function automatic logic [15:0] ref_val(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_val(i);
    endfunction

    function automatic logic [63:0] model_line(input logic [31:0] a);
        int rb;
        logic [63:0] l;
        rb = hw_index(a) - hw_index(a) % 4;
        l = '0;
        for (int k = 0; k < 4; k++) l = l | (64'(ref_val(rb + k)) << (16 * k));
        return l;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic op(input string nm, input logic w, input logic r, input logic hold,
                      input logic [31:0] a, input logic [31:0] d, input logic [63:0] exp_rd);
        int lowc, wec, wb;
        lowc = 0;
        wec  = 0;
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; writeData = d;
        #1;
        while (!ready && lowc < 4 * LATENCY) begin
            lowc++;
            if (!SRAM_WE_N) wec++;
            @(negedge clk);
            address = $urandom; writeData = $urandom;
            if (!hold) begin wr_en = 1'b0; rd_en = 1'b0; end
            #1;
        end
        chk({nm, " freeze"}, 64'(lowc), 64'(LATENCY));
        chk({nm, " we_n_low"}, 64'(wec), w ? 64'd2 : 64'd0);
        chk({nm, " readData"}, readData, exp_rd);
        wr_en = 1'b0; rd_en = 1'b0;
        if (w) begin
            wb = hw_index(a) - hw_index(a) % 2;
            chk({nm, " sram_lo"}, 64'(sram_at(wb)), 64'(d[15:0]));
            chk({nm, " sram_hi"}, 64'(sram_at(wb + 1)), 64'(d[31:16]));
            ref_mem[wb] = d[15:0];
            ref_mem[wb + 1] = d[31:16];
        end
        ref_rd = exp_rd;
    endtask

    typedef struct {
        logic        w, r, hold;
        logic [31:0] a, d;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] old9;
        logic [31:0] ra;
        int sel, gap;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'd1024,       32'hDEADBEEF, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'd1026,       32'h0,        64'h03040102_DEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'd1032,       32'h0,        64'h44443333_22221111};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd1036,       32'h0,        64'h44443333_22221111};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'd1030,       32'hCAFEF00D, 64'h44443333_22221111};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd1024,       32'h0,        64'hCAFEF00D_DEADBEEF};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd1023,       32'h0,        64'h00A300A2_00A100A0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0008_0408,  32'h66665555, 64'h00A300A2_00A100A0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'd1032,       32'h0,        64'h44443333_66665555};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        sram_oe = 1'b1;
        @(negedge clk); #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset readData", readData, 64'h0);
        chk("reset we_n", 64'(SRAM_WE_N), 64'd1);
        chk("reset addr", 64'(SRAM_ADDR), 64'd0);
        chk("reset dq_free", 64'(SRAM_DQ), 64'(init_val(0)));

        for (int i = 0; i < 9; i++)
            op($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].hold, tbl[i].a, tbl[i].d, tbl[i].exp);

        old9 = ref_val(9);
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; writeData = 32'h7777_8888;
        repeat (2) @(negedge clk);
        rst = 1'b1; #1;
        chk("rst_mid readData", readData, 64'h0);
        chk("rst_mid we_n", 64'(SRAM_WE_N), 64'd1);
        chk("rst_mid addr", 64'(SRAM_ADDR), 64'd0);
        @(negedge clk);
        wr_en = 1'b0; #1;
        chk("rst_mid ready", 64'(ready), 64'd1);
        rst = 1'b0;
        chk("rst_mid hw0", 64'(sram_at(8)), 64'h8888);
        chk("rst_mid hw1", 64'(sram_at(9)), 64'(old9));
        ref_mem[8] = 16'h8888;
        op("after_rst", 1'b0, 1'b1, 1'b1, 32'd1040, 32'h0, model_line(32'd1040));

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk); #1;
                chk($sformatf("rnd%0d idle_ready", i), 64'(ready), 64'd1);
            end
            sel = $urandom_range(0, 2);
            ra = ($urandom_range(0, 2) == 0) ? $urandom :
                 ($urandom_range(0, 1) == 0) ? 32'(BASE) + $urandom_range(0, 63) :
                                               32'(BASE) - $urandom_range(1, 16);
            op($sformatf("rnd%0d", i), sel != 1, sel != 0, 1'($urandom_range(0, 1)), ra, $urandom,
               (sel != 1) ? ref_rd : model_line(ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
